multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters SHALL be none; all encodings SHALL come from the shared package.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  7  instruction opcode bits [6:0], from the instruction register.
REQ-005 funct3  in  3  instruction bits [14:12].
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 PCWrite  out  1  PC register enable.
REQ-009 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 MemWrite  out  1  data memory write strobe.
REQ-011 IRWrite  out  1  instruction register enable.
REQ-012 ResultSrc  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-013 ALUSrcA  out  2  A mux select: 00 = PC, 01 = OldPC, 10 = rs1 data.
REQ-014 ALUSrcB  out  2  B mux select: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
REQ-015 RegWrite  out  1  register file write enable.
REQ-016 ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-017 ALUControl  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.

Function
REQ-018 States SHALL be Fetch, Decode, MemAdr, MemRead, MemWB, MemWrite, ExecuteR, ExecuteI, ALUWB, BEQ, JAL; one state per cycle.
REQ-019 Fetch SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1, and SHALL go to Decode.
REQ-020 Decode SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-021 Decode next state SHALL be selected by op: 0000011/0100011 -> MemAdr; 0110011 -> ExecuteR; 0010011 -> ExecuteI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> Fetch with no strobe.
REQ-022 MemAdr SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state SHALL be MemRead if op=0000011, else MemWrite.
REQ-023 MemRead SHALL drive ResultSrc=00, AdrSrc=1, and SHALL go to MemWB.
REQ-024 MemWB SHALL drive ResultSrc=01, RegWrite=1, and SHALL go to Fetch.
REQ-025 MemWrite state SHALL drive ResultSrc=00, AdrSrc=1, MemWrite=1, and SHALL go to Fetch.
REQ-026 ExecuteR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10, and SHALL go to ALUWB.
REQ-027 ExecuteI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10, and SHALL go to ALUWB.
REQ-028 ALUWB SHALL drive ResultSrc=00, RegWrite=1, and SHALL go to Fetch.
REQ-029 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, and SHALL go to Fetch.
REQ-030 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, and SHALL go to ALUWB.
REQ-031 Any output not listed for a state SHALL be 0 in that state; outputs SHALL never be X.
REQ-032 PCWrite SHALL equal PCUpdate | (Branch & zero), combinationally.
REQ-033 ALUControl from ALUOp SHALL be: 00 -> 000; 01 -> 001; 10 -> decoded from funct3.
REQ-034 ALUOp=10 decode SHALL be: funct3 000 -> 001 if {op[5],funct7b5}=11, else 000; 010 -> 101; 110 -> 011; 111 -> 010; other -> 000.
REQ-035 ImmSrc SHALL be combinational from op: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; else 00.
REQ-036 Cycle counts SHALL be: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, unknown op 2.

Reset
REQ-037 While reset=1 at a rising edge, the state SHALL become Fetch, including mid-instruction; any in-flight instruction is abandoned.
REQ-038 While reset=1, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0.
REQ-039 While reset=1, all other outputs SHALL take their Fetch values.

Structure
REQ-040 Package riscv_pkg SHALL hold the state enum, opcode constants, the ALUOp encoding and the ALUControl encoding.
REQ-041 The ALU decoder (REQ-033/034) SHALL be a sub-module named alu_decoder.
REQ-042 The state register and the next-state/output logic SHALL live in multicycle_controller.

Verification
REQ-043 Reset, then op=0000011 -> states Fetch, Decode, MemAdr, MemRead, MemWB; RegWrite=1 only in cycle 5 with ResultSrc=01; ALUControl=000 in every cycle.
REQ-044 op=0110011, funct3=000: funct7b5=1 -> ALUControl=001 in ExecuteR; funct7b5=0 -> 000; funct3=010 -> 101; funct3=110 -> 011; funct3=111 -> 010.
REQ-045 op=1100011, zero=1 -> PCWrite=1 and ALUControl=001 in BEQ; with zero=0 -> PCWrite=0; next state Fetch in both cases.
REQ-046 op=0100011 -> MemWrite=1 only in cycle 4 with AdrSrc=1; ImmSrc=01; RegWrite never 1.
REQ-047 op=1101111 -> ImmSrc=11; PCWrite=1 in JAL; RegWrite=1 with ResultSrc=00 in the following ALUWB.
REQ-048 reset=1 during MemAdr of an lw -> Fetch next cycle with no RegWrite/MemWrite pulse; op=0000000 -> Decode then Fetch with no strobes.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// the ALUOp and ALUControl encodings, and the control-word bundle.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXECUTE_R,
        S_EXECUTE_I,
        S_ALU_WB,
        S_BEQ,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_FETCH = '{
        pc_update:  1'b1,
        branch:     1'b0,
        adr_src:    1'b0,
        mem_write:  1'b0,
        ir_write:   1'b1,
        reg_write:  1'b0,
        result_src: 2'b10,
        alu_src_a:  2'b00,
        alu_src_b:  2'b10,
        alu_op:     ALUOP_ADD
    };

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields and flags into the controller, control strobes and selects out.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;

    modport master (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl
    );

    modport slave (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction function bits onto an ALU operation.
module alu_decoder
    import riscv_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_ctrl_t  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // sub only for R-type with funct7b5 set; addi never subtracts
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller: state register, next-state logic and
// registered per-state control word, with combinational PCWrite/ImmSrc/ALUControl.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    multicycle_controller_if.slave   bus
);

    state_t    state;
    state_t    state_next;
    ctrl_t     ctrl_q;
    ctrl_t     ctrl_out;
    alu_ctrl_t alu_control;

    function automatic state_t next_of(input state_t s, input logic [6:0] op);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH: n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = S_MEM_ADR;
                    OP_R:         n = S_EXECUTE_R;
                    OP_I:         n = S_EXECUTE_I;
                    OP_BEQ:       n = S_BEQ;
                    OP_JAL:       n = S_JAL;
                    default:      n = S_FETCH;
                endcase
            end
            S_MEM_ADR:   n = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  n = S_MEM_WB;
            S_EXECUTE_R: n = S_ALU_WB;
            S_EXECUTE_I: n = S_ALU_WB;
            S_JAL:       n = S_ALU_WB;
            default:     n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        c.alu_op = ALUOP_ADD;
        case (s)
            S_FETCH:  c = CTRL_FETCH;
            S_DECODE: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            S_MEM_ADR: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            S_MEM_READ: c.adr_src = 1'b1;
            S_MEM_WB: begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            S_MEM_WRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            S_EXECUTE_R: begin c.alu_src_a = 2'b10; c.alu_op = ALUOP_FUNCT; end
            S_EXECUTE_I: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: c.reg_write = 1'b1;
            S_BEQ: begin c.alu_src_a = 2'b10; c.alu_op = ALUOP_SUB; c.branch = 1'b1; end
            S_JAL: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb state_next = next_of(state, bus.op);

    // Control word is registered alongside the state so it always matches it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            ctrl_q <= CTRL_FETCH;
        end else begin
            state  <= state_next;
            ctrl_q <= ctrl_for(state_next);
        end
    end

    // Reset overrides the live word immediately so nothing strobes mid-reset.
    always_comb begin
        ctrl_out = ctrl_q;
        if (reset) begin
            ctrl_out           = CTRL_FETCH;
            ctrl_out.pc_update = 1'b0;
            ctrl_out.ir_write  = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl_out.alu_op),
        .op5         (bus.op[5]),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .alu_control (alu_control)
    );

    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    assign bus.PCWrite    = ctrl_out.pc_update | (ctrl_out.branch & bus.zero);
    assign bus.AdrSrc     = ctrl_out.adr_src;
    assign bus.MemWrite   = ctrl_out.mem_write;
    assign bus.IRWrite    = ctrl_out.ir_write;
    assign bus.RegWrite   = ctrl_out.reg_write;
    assign bus.ResultSrc  = ctrl_out.result_src;
    assign bus.ALUSrcA    = ctrl_out.alu_src_a;
    assign bus.ALUSrcB    = ctrl_out.alu_src_b;
    assign bus.ALUControl = alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: instruction-level phase model compared every cycle,
// directed literal checks, then randomized instruction/zero/reset stimulus.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic       regw;
        logic [1:0] imm;
        logic [2:0] aluc;
    } out_t;

    localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MWR = 5;
    localparam int PH_ER = 6, PH_EI = 7, PH_AW = 8, PH_B = 9, PH_J = 10;

    // Instruction classes: 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, 6 unknown
    int seq [7][5] = '{
        '{PH_F, PH_D, PH_MA, PH_MR, PH_MWB},
        '{PH_F, PH_D, PH_MA, PH_MWR, PH_F},
        '{PH_F, PH_D, PH_ER, PH_AW, PH_F},
        '{PH_F, PH_D, PH_EI, PH_AW, PH_F},
        '{PH_F, PH_D, PH_J, PH_AW, PH_F},
        '{PH_F, PH_D, PH_B, PH_F, PH_F},
        '{PH_F, PH_D, PH_F, PH_F, PH_F}
    };
    int seq_len [7] = '{5, 4, 4, 4, 4, 3, 2};

    int   cls = 6;
    int   step = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    out_t last_got;
    out_t hist [16];

    function automatic int cls_of(input logic [6:0] o);
        case (o)
            7'b0000011: return 0;
            7'b0100011: return 1;
            7'b0110011: return 2;
            7'b0010011: return 3;
            7'b1101111: return 4;
            7'b1100011: return 5;
            default:    return 6;
        endcase
    endfunction

    function automatic out_t model_out(input int ph_in, input logic rst, input logic [6:0] o,
                                       input logic [2:0] f3, input logic f7, input logic z);
        out_t e;
        logic pcu, br;
        logic [1:0] aop;
        int ph;
        e = '0; pcu = 1'b0; br = 1'b0; aop = 2'b00;
        ph = rst ? PH_F : ph_in;
        case (ph)
            PH_F:   begin e.irw = 1'b1; e.srcb = 2'b10; e.res = 2'b10; pcu = 1'b1; end
            PH_D:   begin e.srca = 2'b01; e.srcb = 2'b01; end
            PH_MA:  begin e.srca = 2'b10; e.srcb = 2'b01; end
            PH_MR:  e.adr = 1'b1;
            PH_MWB: begin e.res = 2'b01; e.regw = 1'b1; end
            PH_MWR: begin e.adr = 1'b1; e.memw = 1'b1; end
            PH_ER:  begin e.srca = 2'b10; aop = 2'b10; end
            PH_EI:  begin e.srca = 2'b10; e.srcb = 2'b01; aop = 2'b10; end
            PH_AW:  e.regw = 1'b1;
            PH_B:   begin e.srca = 2'b10; aop = 2'b01; br = 1'b1; end
            PH_J:   begin e.srca = 2'b01; e.srcb = 2'b10; pcu = 1'b1; end
            default: e = '0;
        endcase
        e.pcw = pcu | (br & z);
        if (rst) begin e.pcw = 1'b0; e.irw = 1'b0; end
        e.imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
                (o == 7'b1101111) ? 2'b11 : 2'b00;
        if (aop == 2'b01) e.aluc = 3'b001;
        else if (aop == 2'b10) begin
            case (f3)
                3'b000:  e.aluc = (o[5] && f7) ? 3'b001 : 3'b000;
                3'b010:  e.aluc = 3'b101;
                3'b110:  e.aluc = 3'b011;
                3'b111:  e.aluc = 3'b010;
                default: e.aluc = 3'b000;
            endcase
        end else e.aluc = 3'b000;
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        out_t got, exp;
        @(negedge clk);
        got.pcw  = bus.PCWrite;   got.adr  = bus.AdrSrc;   got.memw = bus.MemWrite;
        got.irw  = bus.IRWrite;   got.res  = bus.ResultSrc; got.srca = bus.ALUSrcA;
        got.srcb = bus.ALUSrcB;   got.regw = bus.RegWrite; got.imm  = bus.ImmSrc;
        got.aluc = bus.ALUControl;
        exp = model_out(seq[cls][step], reset, bus.op, bus.funct3, bus.funct7b5, bus.zero);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL model_cycle cls=%0d step=%0d rst=%0b: got %h expected %h",
                     cls, step, reset, got, exp);
        end
        last_got = got;
        @(posedge clk);
        if (reset || step >= seq_len[cls] - 1) step = 0;
        else step++;
        #1;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int exp_len, input string name);
        int n;
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
        cls = cls_of(o);
        n = 0;
        do begin
            tick();
            hist[n] = last_got;
            n++;
        end while (!bus.IRWrite && n < 12);
        chk({name, "_cycles"}, n, exp_len);
    endtask

    initial begin
        bus.op = 7'b0; bus.funct3 = 3'b0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk("reset_irwrite", int'(last_got.irw), 0);
        chk("reset_srcb", int'(last_got.srcb), 2);
        chk("reset_result", int'(last_got.res), 2);
        reset = 1'b0;

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 5, "lw");
        chk("lw_regw_c5", int'(hist[4].regw), 1);
        chk("lw_res_c5", int'(hist[4].res), 1);
        chk("lw_regw_c4", int'(hist[3].regw), 0);
        chk("lw_aluc_c3", int'(hist[2].aluc), 0);

        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 4, "sub");
        chk("sub_aluc", int'(hist[2].aluc), 1);
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 4, "add");
        chk("add_aluc", int'(hist[2].aluc), 0);
        run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 4, "slt");
        chk("slt_aluc", int'(hist[2].aluc), 5);
        run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 4, "or");
        chk("or_aluc", int'(hist[2].aluc), 3);
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 4, "and");
        chk("and_aluc", int'(hist[2].aluc), 2);
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 4, "addi");
        chk("addi_aluc", int'(hist[2].aluc), 0);

        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 3, "beq_taken");
        chk("beq_taken_pcw", int'(hist[2].pcw), 1);
        chk("beq_aluc", int'(hist[2].aluc), 1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 3, "beq_not");
        chk("beq_not_pcw", int'(hist[2].pcw), 0);

        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 4, "sw");
        chk("sw_memw_c4", int'(hist[3].memw), 1);
        chk("sw_adr_c4", int'(hist[3].adr), 1);
        chk("sw_memw_c3", int'(hist[2].memw), 0);
        chk("sw_imm", int'(hist[1].imm), 1);

        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 4, "jal");
        chk("jal_imm", int'(hist[1].imm), 3);
        chk("jal_pcw", int'(hist[2].pcw), 1);
        chk("jal_regw", int'(hist[3].regw), 1);
        chk("jal_res", int'(hist[3].res), 0);

        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 2, "unknown");
        chk("unknown_strobes", int'({hist[1].pcw, hist[1].memw, hist[1].irw, hist[1].regw}), 0);

        // lw abandoned by reset during MemAdr
        bus.op = 7'b0000011; cls = cls_of(bus.op);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("abort_strobes", int'({last_got.memw, last_got.regw, last_got.pcw}), 0);
        reset = 1'b0;
        tick();
        chk("abort_fetch_irw", int'(last_got.irw), 1);
        chk("abort_fetch_res", int'(last_got.res), 2);

        for (int c = 0; c < 3000; c++) begin
            if (step == 0) begin
                case ($urandom_range(0, 7))
                    0: bus.op = 7'b0000011;
                    1: bus.op = 7'b0100011;
                    2: bus.op = 7'b0110011;
                    3: bus.op = 7'b0010011;
                    4: bus.op = 7'b1101111;
                    5: bus.op = 7'b1100011;
                    default: bus.op = 7'($urandom);
                endcase
                bus.funct3   = 3'($urandom);
                bus.funct7b5 = 1'($urandom);
                cls = cls_of(bus.op);
            end
            bus.zero = 1'($urandom);
            reset = ($urandom_range(0, 39) == 0);
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
